// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioner: repeat-state encoding and
// default channel indices for the Basys3 five-button cluster.
package btn_pkg;

    localparam int unsigned BTN_STATE_W = 2;

    typedef enum logic [BTN_STATE_W-1:0] {
        BTN_IDLE   = 2'd0,
        BTN_DELAY  = 2'd1,
        BTN_REPEAT = 2'd2
    } btn_rpt_state_e;

    // Default bit positions of the Basys3 buttons in btn_in
    localparam int unsigned BTN_UP     = 0;
    localparam int unsigned BTN_DOWN   = 1;
    localparam int unsigned BTN_LEFT   = 2;
    localparam int unsigned BTN_RIGHT  = 3;
    localparam int unsigned BTN_CENTER = 4;

endpackage

// File: rtl/btn_channel.sv
// One button channel: two-flop synchroniser, counter debouncer, registered edge pulses
// and, when BTN_AUTOREPEAT_EN is defined, an IDLE/DELAY/REPEAT auto-repeat FSM.
module btn_channel
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 32,
    parameter int unsigned REPEAT_DELAY    = 50_000_000,
    parameter int unsigned REPEAT_PERIOD   = 10_000_000
) (
    input  logic clk,
    input  logic i_clr,
    input  logic i_btn,
    output logic o_level,
    output logic o_rise,
    output logic o_fall,
    output logic o_press
);

    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic            r_s1;
    logic            r_s2;
    logic            r_level;
    logic            r_rise;
    logic            r_fall;
    logic [DB_W-1:0] r_db_cnt;
    logic            w_diff;
    logic            w_accept;

    // A new level is accepted once it has disagreed with btn_level long enough
    assign w_diff   = r_s2 ^ r_level;
    assign w_accept = w_diff && (r_db_cnt == DB_W'(DEBOUNCE_CYCLES));

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_s1     <= 1'b0;
            r_s2     <= 1'b0;
            r_level  <= 1'b0;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
            r_db_cnt <= '0;
        end else begin
            r_s1     <= i_btn;
            r_s2     <= r_s1;
            r_db_cnt <= (!w_diff || w_accept) ? '0 : r_db_cnt + DB_W'(1);
            if (w_accept) begin
                r_level <= ~r_level;
            end
            r_rise <= w_accept && !r_level;
            r_fall <= w_accept && r_level;
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

`ifdef BTN_AUTOREPEAT_EN
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

    btn_rpt_state_e   r_state;
    btn_rpt_state_e   w_state_nxt;
    logic [RPT_W-1:0] r_rpt_cnt;
    logic [RPT_W-1:0] w_rpt_cnt_nxt;
    logic             r_press;
    logic             w_press_nxt;

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_state   <= BTN_IDLE;
            r_rpt_cnt <= '0;
            r_press   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_rpt_cnt <= w_rpt_cnt_nxt;
            r_press   <= w_press_nxt;
        end
    end

    // An accepted fall overrides any repeat tick due in the same cycle
    always_comb begin
        w_state_nxt   = r_state;
        w_rpt_cnt_nxt = r_rpt_cnt + RPT_W'(1);
        w_press_nxt   = 1'b0;
        if (w_accept && r_level) begin
            w_state_nxt   = BTN_IDLE;
            w_rpt_cnt_nxt = '0;
        end else begin
            case (r_state)
                BTN_IDLE: begin
                    w_rpt_cnt_nxt = '0;
                    if (w_accept) begin
                        w_state_nxt = BTN_DELAY;
                        w_press_nxt = 1'b1;
                    end
                end
                BTN_DELAY: begin
                    if (r_rpt_cnt == RPT_W'(REPEAT_DELAY - 1)) begin
                        w_state_nxt   = BTN_REPEAT;
                        w_rpt_cnt_nxt = '0;
                        w_press_nxt   = 1'b1;
                    end
                end
                BTN_REPEAT: begin
                    if (r_rpt_cnt == RPT_W'(REPEAT_PERIOD - 1)) begin
                        w_rpt_cnt_nxt = '0;
                        w_press_nxt   = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt   = BTN_IDLE;
                    w_rpt_cnt_nxt = '0;
                end
            endcase
        end
    end

    assign o_press = r_press;
`else
    // Repeat timing has no effect without auto-repeat; press is simply the rise pulse
    logic w_unused_rpt_cfg;
    assign w_unused_rpt_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
    assign o_press          = r_rise;
`endif

endmodule

// File: rtl/btn_conditioner.sv
// Multi-channel push-button conditioner: CHANNELS independent btn_channel instances.
// Auto-repeat is compiled in only when BTN_AUTOREPEAT_EN is defined.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int unsigned CHANNELS        = 5,
    parameter int unsigned DEBOUNCE_CYCLES = 32,
    parameter int unsigned REPEAT_DELAY    = 50_000_000,
    parameter int unsigned REPEAT_PERIOD   = 10_000_000
) (
    input  logic                clk,
    input  logic                clr,
    input  logic [CHANNELS-1:0] btn_in,
    output logic [CHANNELS-1:0] btn_level,
    output logic [CHANNELS-1:0] btn_rise,
    output logic [CHANNELS-1:0] btn_fall,
    output logic [CHANNELS-1:0] btn_press
);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        btn_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_channel (
            .clk     (clk),
            .i_clr   (clr),
            .i_btn   (btn_in[g]),
            .o_level (btn_level[g]),
            .o_rise  (btn_rise[g]),
            .o_fall  (btn_fall[g]),
            .o_press (btn_press[g])
        );
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: directed scenarios plus random bouncing inputs, all checked
// every cycle against a sample-window reference model.
module tb_btn_conditioner;

    localparam int unsigned CH = 5;
    localparam int unsigned DB = 4;
    localparam int unsigned RD = 10;
    localparam int unsigned RP = 3;
    localparam int unsigned HL = DB + 3;

    logic          clk = 1'b0;
    logic          clr;
    logic [CH-1:0] btn_in;
    logic [CH-1:0] btn_level;
    logic [CH-1:0] btn_rise;
    logic [CH-1:0] btn_fall;
    logic [CH-1:0] btn_press;

    always #5 clk = ~clk;

    btn_conditioner #(
        .CHANNELS        (CH),
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .btn_in    (btn_in),
        .btn_level (btn_level),
        .btn_rise  (btn_rise),
        .btn_fall  (btn_fall),
        .btn_press (btn_press)
    );

    // Reference model: hist[k] is btn_in as sampled k edges ago (zeroed by reset)
    logic [CH-1:0] hist [HL];
    logic [CH-1:0] m_level;
    logic [CH-1:0] m_rise;
    logic [CH-1:0] m_fall;
    logic [CH-1:0] m_press;
    int unsigned   m_age [CH];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic model_edge(input logic r, input logic [CH-1:0] b);
        logic acc;
        if (r) begin
            for (int k = 0; k < HL; k++) hist[k] = '0;
            m_level = '0;
            m_rise  = '0;
            m_fall  = '0;
            m_press = '0;
            for (int c = 0; c < CH; c++) m_age[c] = 0;
        end else begin
            for (int k = HL - 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = b;
            for (int c = 0; c < CH; c++) begin
                // Accept when the synchronised samples of the last DB+1 edges all disagree
                acc = 1'b1;
                for (int k = 2; k <= DB + 2; k++) begin
                    if (hist[k][c] == m_level[c]) acc = 1'b0;
                end
                m_rise[c] = acc && !m_level[c];
                m_fall[c] = acc && m_level[c];
                if (acc) m_level[c] = !m_level[c];
`ifdef BTN_AUTOREPEAT_EN
                if (m_rise[c]) begin
                    m_age[c]   = 0;
                    m_press[c] = 1'b1;
                end else if (m_level[c]) begin
                    m_age[c]   = m_age[c] + 1;
                    m_press[c] = (m_age[c] == RD) ||
                                 ((m_age[c] > RD) && (((m_age[c] - RD) % RP) == 0));
                end else begin
                    m_age[c]   = 0;
                    m_press[c] = 1'b0;
                end
`else
                m_press[c] = m_rise[c];
`endif
            end
        end
    endtask

    task automatic chk(input string tag, input logic [CH-1:0] obs, input logic [CH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s @cyc%0d: observed %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s @cyc%0d: observed %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    // One clock edge: advance model with the inputs seen at the edge, then compare
    task automatic step(input string tag);
        @(posedge clk);
        model_edge(clr, btn_in);
        #1;
        cyc++;
        chk({tag, "/level"}, btn_level, m_level);
        chk({tag, "/rise"},  btn_rise,  m_rise);
        chk({tag, "/fall"},  btn_fall,  m_fall);
        chk({tag, "/press"}, btn_press, m_press);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    int            n_press;
    int            rise_at;
    int unsigned   p;
    logic [CH-1:0] seen;

    initial begin
        clr    = 1'b1;
        btn_in = '0;
        idle("reset", 3);
        chk("reset_level", btn_level, '0);
        chk("reset_press", btn_press, '0);
        clr = 1'b0;
        idle("quiet", 4);

        // Clean press on channel 0: level and rise appear together at edge 6
        btn_in[0] = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            step("clean");
            if (i == 5) chk("clean_level_e5", btn_level & 5'b00001, 5'b00000);
            if (i == 6) chk("clean_rise_e6", btn_rise & btn_press & 5'b00001, 5'b00001);
            if (i == 7) chk("clean_rise_e7", btn_rise & 5'b00001, 5'b00000);
        end
        btn_in[0] = 1'b0;
        idle("clean_rel", 10);

        // Glitch of 3 cycles on channel 1 is rejected
        seen = '0;
        btn_in[1] = 1'b1;
        for (int i = 0; i < 14; i++) begin
            if (i == 3) btn_in[1] = 1'b0;
            step("glitch");
            seen = seen | btn_level | btn_rise | btn_press;
        end
        chk("glitch_none", seen & 5'b00010, 5'b00000);

        // Auto-repeat on channel 2, held 30 cycles past acceptance
        btn_in[2] = 1'b1;
        idle("rpt_deb", 6);
        n_press = 0;
        for (int t = 0; t <= 30; t++) begin
            step("rpt_hold");
            if (btn_press[2]) n_press++;
        end
`ifdef BTN_AUTOREPEAT_EN
        chk_int("rpt_press_count", n_press, 8);
`else
        chk_int("rpt_press_count", n_press, 1);
`endif
        btn_in[2] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step("rpt_rel");
            if (btn_fall[2]) chk("rpt_fall_nopress", btn_press & 5'b00100, 5'b00000);
        end

        // Reset while repeating with the button still held
        btn_in[2] = 1'b1;
        idle("rst_pre", 22);
        clr = 1'b1;
        step("rst_clr");
        chk("rst_all_zero", btn_level | btn_rise | btn_fall | btn_press, '0);
        clr     = 1'b0;
        rise_at = -1;
        for (int i = 1; i <= 10; i++) begin
            step("rst_post");
            if (btn_rise[2] && rise_at < 0) rise_at = i;
        end
        chk_int("rst_rise_edge", rise_at, 7);
        btn_in[2] = 1'b0;
        idle("rst_rel", 10);

        // Simultaneous press on channels 0 and 4
        btn_in = 5'b10001;
        for (int i = 0; i <= 7; i++) begin
            step("simul");
            if (i == 6) chk("simul_rise", btn_rise, 5'b10001);
        end
        btn_in = '0;
        idle("simul_rel", 10);

        // Random bouncing: fast toggling first, then long holds to exercise repeat
        for (int n = 0; n < 3000; n++) begin
            p = (n < 1500) ? 12 : 2;
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 99) < p) btn_in[c] = ~btn_in[c];
            end
            clr = ($urandom_range(0, 699) == 0);
            step("rand");
        end
        clr    = 1'b0;
        btn_in = '0;
        idle("drain", 10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
